// File: rtl/regfile_ctrl_pkg.sv
// Shared types, field map and decode helper for the register-file controller.
// REGFILE_CTRL_SHIFT_EN (see regfile_ctrl_alu) enables the optional Rm shifter.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StRdA,
        StRdB,
        StExec,
        StWb,
        StDone
    } state_e;

    // Instruction classes; also used as the ALU operation select.
    typedef enum logic [2:0] {
        ClsIllegal,
        ClsMovImm,
        ClsMovReg,
        ClsAdd,
        ClsCmp,
        ClsAnd,
        ClsMvn
    } cls_e;

    localparam logic [2:0] OpcMov   = 3'b110;
    localparam logic [2:0] OpcAlu   = 3'b101;

    localparam logic [1:0] OpMovImm = 2'b10;
    localparam logic [1:0] OpMovReg = 2'b00;
    localparam logic [1:0] OpAdd    = 2'b00;
    localparam logic [1:0] OpCmp    = 2'b01;
    localparam logic [1:0] OpAnd    = 2'b10;
    localparam logic [1:0] OpMvn    = 2'b11;

    localparam logic [1:0] ShNone   = 2'b00;
    localparam logic [1:0] ShLsl1   = 2'b01;
    localparam logic [1:0] ShLsr1   = 2'b10;
    localparam logic [1:0] ShAsr1   = 2'b11;

    localparam int unsigned OpcMsb = 15;
    localparam int unsigned OpcLsb = 13;
    localparam int unsigned OpMsb  = 12;
    localparam int unsigned OpLsb  = 11;
    localparam int unsigned RnMsb  = 10;
    localparam int unsigned RnLsb  = 8;
    localparam int unsigned RdMsb  = 7;
    localparam int unsigned RdLsb  = 5;
    localparam int unsigned ShMsb  = 4;
    localparam int unsigned ShLsb  = 3;
    localparam int unsigned RmMsb  = 2;
    localparam int unsigned RmLsb  = 0;
    localparam int unsigned ImmMsb = 7;
    localparam int unsigned ImmLsb = 0;

    function automatic cls_e decode(input logic [2:0] opc, input logic [1:0] op);
        cls_e cls;
        cls = ClsIllegal;
        if (opc == OpcMov) begin
            if (op == OpMovImm) begin
                cls = ClsMovImm;
            end else if (op == OpMovReg) begin
                cls = ClsMovReg;
            end
        end else if (opc == OpcAlu) begin
            unique case (op)
                OpAdd:   cls = ClsAdd;
                OpCmp:   cls = ClsCmp;
                OpAnd:   cls = ClsAnd;
                OpMvn:   cls = ClsMvn;
                default: cls = ClsIllegal;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/regfile_ctrl_alu.sv
// Combinational shifter + ALU. Flags always reflect A - sh(B) and are only
// consumed by CMP. Shifter present only when REGFILE_CTRL_SHIFT_EN is defined.
module regfile_ctrl_alu
    import regfile_ctrl_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  cls_e        op_i,
    input  logic [1:0]  sh_i,
    output logic [15:0] result_o,
    output logic        n_o,
    output logic        v_o,
    output logic        z_o
);

    logic [15:0] b_sh;
    logic [15:0] diff;

`ifdef REGFILE_CTRL_SHIFT_EN
    always_comb begin
        b_sh = b_i;
        unique case (sh_i)
            ShNone:  b_sh = b_i;
            ShLsl1:  b_sh = {b_i[14:0], 1'b0};
            ShLsr1:  b_sh = {1'b0, b_i[15:1]};
            ShAsr1:  b_sh = {b_i[15], b_i[15:1]};
            default: b_sh = b_i;
        endcase
    end
`else
    logic unused_sh;
    assign unused_sh = ^sh_i;
    assign b_sh      = b_i;
`endif

    assign diff = a_i - b_sh;

    always_comb begin
        result_o = '0;
        unique case (op_i)
            ClsAdd:    result_o = a_i + b_sh;
            ClsCmp:    result_o = diff;
            ClsAnd:    result_o = a_i & b_sh;
            ClsMvn:    result_o = ~b_sh;
            ClsMovReg: result_o = b_sh;
            default:   result_o = '0;
        endcase
    end

    // Subtraction overflows when operand signs differ and the result sign flips from A.
    assign n_o = diff[15];
    assign z_o = (diff == 16'd0);
    assign v_o = (a_i[15] != b_sh[15]) && (diff[15] != a_i[15]);

endmodule

// File: rtl/regfile_ctrl.sv
// Multi-cycle controller that executes one 16-bit instruction against an
// external 8x16 register file. Optional shifter: define REGFILE_CTRL_SHIFT_EN.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  status,
    output logic [2:0]  rf_readnum,
    input  logic [15:0] rf_rdata,
    output logic [2:0]  rf_writenum,
    output logic        rf_write,
    output logic [15:0] rf_wdata
);

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] c_q, c_d;
    logic [2:0]  status_q, status_d;

    cls_e        cls;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [15:0] imm_sx;
    logic [15:0] alu_result;
    logic        alu_n, alu_v, alu_z;

    assign cls    = decode(instr_q[OpcMsb:OpcLsb], instr_q[OpMsb:OpLsb]);
    assign rn     = instr_q[RnMsb:RnLsb];
    assign rd     = instr_q[RdMsb:RdLsb];
    assign rm     = instr_q[RmMsb:RmLsb];
    assign sh     = instr_q[ShMsb:ShLsb];
    assign imm_sx = {{8{instr_q[ImmMsb]}}, instr_q[ImmMsb:ImmLsb]};

    regfile_ctrl_alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (cls),
        .sh_i     (sh),
        .result_o (alu_result),
        .n_o      (alu_n),
        .v_o      (alu_v),
        .z_o      (alu_z)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        status_d    = status_q;
        done        = 1'b0;
        err         = 1'b0;
        rf_readnum  = 3'd0;
        rf_writenum = 3'd0;
        rf_write    = 1'b0;
        rf_wdata    = 16'd0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    instr_d = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                unique case (cls)
                    ClsMovImm:               state_d = StWb;
                    ClsMovReg, ClsMvn:       state_d = StRdB;
                    ClsAdd, ClsCmp, ClsAnd:  state_d = StRdA;
                    default:                 state_d = StDone;
                endcase
            end
            StRdA: begin
                rf_readnum = rn;
                a_d        = rf_rdata;
                state_d    = StRdB;
            end
            StRdB: begin
                rf_readnum = rm;
                b_d        = rf_rdata;
                state_d    = StExec;
            end
            StExec: begin
                c_d = alu_result;
                if (cls == ClsCmp) begin
                    status_d = {alu_n, alu_v, alu_z};
                    state_d  = StDone;
                end else begin
                    state_d  = StWb;
                end
            end
            StWb: begin
                rf_write = 1'b1;
                if (cls == ClsMovImm) begin
                    rf_writenum = rn;
                    rf_wdata    = imm_sx;
                end else begin
                    rf_writenum = rd;
                    rf_wdata    = c_q;
                end
                state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                err     = (cls == ClsIllegal);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = (state_q != StIdle);
    assign status = status_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            instr_q  <= 16'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            c_q      <= 16'd0;
            status_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl: a behavioural model predicts each
// instruction's outcome; a negedge monitor checks it when done pulses.
module tb_regfile_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  status;
    logic [2:0]  rf_readnum;
    logic [15:0] rf_rdata;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [15:0] rf_wdata;

    regfile_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr       (instr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .status      (status),
        .rf_readnum  (rf_readnum),
        .rf_rdata    (rf_rdata),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file attached to the DUT, with a preload port for the bench.
    logic [15:0] mem [8];
    logic        pl_en;
    logic [2:0]  pl_idx;
    logic [15:0] pl_val;

    assign rf_rdata = mem[rf_readnum];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (rf_write) mem[rf_writenum] <= rf_wdata;
    end

    typedef struct {
        logic [15:0] ins;
        bit          err;
        int          wcnt;
        logic [2:0]  wnum;
        logic [15:0] wdata;
        logic [2:0]  status;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_rf [8];
    logic [2:0]  cur_status;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] shifted(input logic [15:0] b, input logic [1:0] sh);
`ifdef REGFILE_CTRL_SHIFT_EN
        logic signed [15:0] sb;
        int                 v;
        sb = b;
        v  = sb;
        case (sh)
            2'd0:    return b;
            2'd1:    return 16'((int'(b) * 2) % 65536);
            2'd2:    return 16'(int'(b) / 2);
            default: return 16'(v >>> 1);
        endcase
`else
        if (sh == 2'd3) return b;
        return b;
`endif
    endfunction

    // Predicts one instruction from the architectural rules and updates the shadow state.
    function automatic exp_t ref_model(input logic [15:0] ins);
        exp_t              e;
        logic [2:0]        opc, rn, rd, rm;
        logic [1:0]        op, sh;
        logic [15:0]       a, b, res;
        logic signed [7:0] imm;
        int                sa, sb, sd;
        opc = ins[15:13];
        op  = ins[12:11];
        rn  = ins[10:8];
        rd  = ins[7:5];
        sh  = ins[4:3];
        rm  = ins[2:0];
        imm = ins[7:0];
        e.ins = ins; e.err = 1'b0; e.wcnt = 0; e.wnum = 3'd0; e.wdata = 16'd0; e.lat = 0;
        a = ref_rf[rn];
        b = shifted(ref_rf[rm], sh);
        if (opc == 3'd6 && op == 2'd2) begin
            sa = imm;
            e.wcnt = 1; e.wnum = rn; e.wdata = 16'(sa); e.lat = 3;
        end else if (opc == 3'd6 && op == 2'd0) begin
            e.wcnt = 1; e.wnum = rd; e.wdata = b; e.lat = 5;
        end else if (opc == 3'd5) begin
            sa = $signed(a);
            sb = $signed(b);
            case (op)
                2'd0: begin e.wcnt = 1; e.wnum = rd; e.wdata = 16'(sa + sb); e.lat = 6; end
                2'd1: begin
                    sd  = sa - sb;
                    res = 16'(sd);
                    cur_status = {res[15], (sd > 32767 || sd < -32768), (res == 16'd0)};
                    e.lat = 5;
                end
                2'd2: begin e.wcnt = 1; e.wnum = rd; e.wdata = a & b; e.lat = 6; end
                default: begin e.wcnt = 1; e.wnum = rd; e.wdata = ~b; e.lat = 5; end
            endcase
        end else begin
            e.err = 1'b1; e.lat = 2;
        end
        if (e.wcnt != 0) ref_rf[e.wnum] = e.wdata;
        e.status = cur_status;
        return e;
    endfunction

    function automatic bit is_legal(input logic [15:0] ins);
        return (ins[15:13] == 3'd5) || (ins[15:13] == 3'd6 && ins[11] == 1'b0);
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        int          k;
        r = 16'($urandom);
        k = $urandom_range(0, 7);
        case (k)
            0: return {3'b110, 2'b10, r[10:0]};
            1: return {3'b110, 2'b00, r[10:0]};
            2, 3, 4, 5: return {3'b101, 2'(k - 2), r[10:0]};
            6: begin
                while (is_legal(r)) r = 16'($urandom);
                return r;
            end
            default: return r;
        endcase
    endfunction

    // Monitor: counts busy cycles and writes per instruction; checks at done.
    initial begin
        int          cnt, wcnt;
        logic [2:0]  wnum;
        logic [15:0] wdat;
        exp_t        e;
        cnt = 0; wcnt = 0; wnum = 3'd0; wdat = 16'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0; wcnt = 0;
            end else begin
                if (busy) cnt++;
                if (rf_write) begin wcnt++; wnum = rf_writenum; wdat = rf_wdata; end
                if (done) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_without_start: got done=1 expected no pulse at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("latency[%h]", e.ins), 32'(cnt), 32'(e.lat));
                        chk($sformatf("err[%h]", e.ins), 32'(err), 32'(e.err));
                        chk($sformatf("wr_count[%h]", e.ins), 32'(wcnt), 32'(e.wcnt));
                        if (e.wcnt != 0) begin
                            chk($sformatf("wr_num[%h]", e.ins), 32'(wnum), 32'(e.wnum));
                            chk($sformatf("wr_data[%h]", e.ins), 32'(wdat), 32'(e.wdata));
                        end
                        chk($sformatf("status[%h]", e.ins), 32'(status), 32'(e.status));
                        chk($sformatf("readnum_at_done[%h]", e.ins), 32'(rf_readnum), 32'd0);
                    end
                    cnt = 0; wcnt = 0;
                end
            end
        end
    end

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
        ref_rf[idx] = val;
    endtask

    // mode 0: plain; 1: hammer start with junk while busy; 2: return after launch.
    task automatic issue(input logic [15:0] ins, input int mode);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        e = ref_model(ins);
        q.push_back(e);
        start = 1'b1;
        instr = ins;
        @(negedge clk);
        n = 0;
        if (mode == 1) begin
            while (busy && n < 20) begin
                start = 1'b1;
                instr = 16'($urandom);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        if (mode == 0) begin
            while (busy && n < 20) begin @(negedge clk); n++; end
        end
        if (mode != 2) chk($sformatf("idle_after[%h]", ins), 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] saved [8];
        int          n;
        rst_n = 1'b0; start = 1'b0; instr = 16'd0;
        pl_en = 1'b0; pl_idx = 3'd0; pl_val = 16'd0;
        cur_status = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rf_write", 32'(rf_write), 32'd0);
        chk("reset_status", 32'(status), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));

        issue(16'hD3FE, 0);
        preload(3'd1, 16'd5);
        preload(3'd2, 16'd7);
        issue(16'hA102, 0);
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'hFFFF);
        issue(16'hA902, 0);
        chk("cmp_status_nvz", 32'(status), 32'b110);
        preload(3'd2, 16'h8001);
        issue(16'hC09A, 0);
        issue(16'hE000, 0);
        issue(16'hA102, 1);
        issue(16'hE000, 1);

        for (int i = 0; i < 200; i++) begin
            if (i % 16 == 0) preload(3'($urandom_range(0, 7)), 16'($urandom));
            issue(rand_instr(), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        // Reset during WB of an ADD after a CMP left status nonzero.
        preload(3'd1, 16'd0);
        preload(3'd2, 16'd1);
        issue(16'hA902, 0);
        saved = ref_rf;
        issue(16'hA102, 2);
        n = 0;
        while (!rf_write && n < 10) begin @(negedge clk); n++; end
        chk("wb_reached_before_reset", 32'(rf_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        q.delete();
        ref_rf = saved;
        cur_status = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'hD57F, 0);
        issue(16'hA0E5, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
